// File: rtl/ysyx_23060184_mdu_if.sv
// EX-stage handshake between the operand-select logic and the multiply/divide unit.
// master drives the op and the result acceptance; slave is the unit itself.
interface ysyx_23060184_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            Dvalid;
    logic            Eready;
    logic [2:0]      MDOp;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            Flush;
    logic            Evalid;
    logic            Mready;
    logic [XLEN-1:0] MDResult;
    logic            Busy;

    modport master (
        output Dvalid, MDOp, SrcA, SrcB, Flush, Mready,
        input  Eready, Evalid, MDResult, Busy
    );

    modport slave (
        input  Dvalid, MDOp, SrcA, SrcB, Flush, Mready,
        output Eready, Evalid, MDResult, Busy
    );
endinterface

// File: rtl/ysyx_23060184_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, BPC bits per cycle, sign-corrected at the last step.
module ysyx_23060184_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_23060184_mdu_if.slave  mdu
);
    localparam int unsigned N  = XLEN / BPC;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   shreg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;
    logic [CW-1:0]     cnt;

    // Accept-time decode: effective signs, magnitudes and the early-exit cases.
    logic            sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, spec_res;

    always_comb begin
        sgn_a    = mdu.MDOp[2] ? !mdu.MDOp[0] : (mdu.MDOp[1:0] != 2'b11);
        sgn_b    = mdu.MDOp[2] ? !mdu.MDOp[0] : !mdu.MDOp[1];
        neg_a    = sgn_a & mdu.SrcA[XLEN-1];
        neg_b    = sgn_b & mdu.SrcB[XLEN-1];
        abs_a    = neg_a ? -mdu.SrcA : mdu.SrcA;
        abs_b    = neg_b ? -mdu.SrcB : mdu.SrcB;
        div_zero = mdu.MDOp[2] && (mdu.SrcB == '0);
        div_ovf  = mdu.MDOp[2] && !mdu.MDOp[0] && (mdu.SrcA == SMIN) && (mdu.SrcB == '1);
        if (div_zero) spec_res = mdu.MDOp[1] ? mdu.SrcA : '1;
        else          spec_res = mdu.MDOp[1] ? '0 : mdu.SrcA;
    end

    // One iteration: shreg holds the multiplier (MSB first) or the dividend/quotient.
    logic [2*XLEN-1:0] part, acc_nx, prod_fix;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   sh_nx, q_fix, r_fix, result;

    always_comb begin
        part   = '0;
        rem    = acc[XLEN:0];
        sh_nx  = shreg;
        acc_nx = acc;
        if (op[2]) begin
            for (int i = 0; i < BPC; i++) begin
                rem   = {rem[XLEN-1:0], sh_nx[XLEN-1]};
                sh_nx = {sh_nx[XLEN-2:0], 1'b0};
                if (rem >= {1'b0, mag_b}) begin
                    rem      = rem - {1'b0, mag_b};
                    sh_nx[0] = 1'b1;
                end
            end
            acc_nx = {{(XLEN-1){1'b0}}, rem};
        end else begin
            for (int i = 0; i < BPC; i++) begin
                if (shreg[XLEN-BPC+i]) part = part + ({{XLEN{1'b0}}, mag_a} << i);
            end
            acc_nx = (acc << BPC) + part;
            sh_nx  = shreg << BPC;
        end
        prod_fix = neg_q ? -acc_nx : acc_nx;
        q_fix    = neg_q ? -sh_nx : sh_nx;
        r_fix    = neg_r ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        if (op[2]) result = op[1] ? r_fix : q_fix;
        else       result = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            mag_a <= '0;
            mag_b <= '0;
            shreg <= '0;
            acc   <= '0;
            res_q <= '0;
            cnt   <= '0;
        end else if (mdu.Flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (mdu.Dvalid) begin
                    op    <= mdu.MDOp;
                    neg_q <= neg_a ^ neg_b;
                    neg_r <= neg_a;
                    mag_a <= abs_a;
                    mag_b <= abs_b;
                    acc   <= '0;
                    shreg <= mdu.MDOp[2] ? abs_a : abs_b;
                    if (div_zero || div_ovf) begin
                        res_q <= spec_res;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt   <= CW'(N);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_nx;
                    shreg <= sh_nx;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res_q <= result;
                        state <= DONE;
                    end
                end
                DONE: if (mdu.Mready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mdu.Eready   = (state == IDLE);
    assign mdu.Evalid   = (state == DONE);
    assign mdu.Busy     = (state != IDLE);
    assign mdu.MDResult = res_q;
endmodule

// File: tb/tb_ysyx_23060184_mdu.sv
// Scoreboard bench for the MDU: a BPC=1 and a BPC=4 instance share the stimulus.
module tb_ysyx_23060184_mdu;
    logic        clk = 1'b0;
    logic        rst, rst_p;
    logic        dvalid, flush, mready;
    logic [2:0]  mdop;
    logic [31:0] srca, srcb;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q1[$];
    logic [31:0] q4[$];

    always #5 clk = ~clk;

    ysyx_23060184_mdu_if #(.XLEN(32)) bus1 ();
    ysyx_23060184_mdu_if #(.XLEN(32)) bus4 ();

    assign bus1.Dvalid = dvalid;  assign bus4.Dvalid = dvalid;
    assign bus1.MDOp   = mdop;    assign bus4.MDOp   = mdop;
    assign bus1.SrcA   = srca;    assign bus4.SrcA   = srca;
    assign bus1.SrcB   = srcb;    assign bus4.SrcB   = srcb;
    assign bus1.Flush  = flush;   assign bus4.Flush  = flush;
    assign bus1.Mready = mready;  assign bus4.Mready = mready;

    ysyx_23060184_mdu #(.XLEN(32), .BPC(1)) dut1 (.clk(clk), .rst(rst), .mdu(bus1));
    ysyx_23060184_mdu #(.XLEN(32), .BPC(4)) dut4 (.clk(clk), .rst(rst | rst_p), .mdu(bus4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic for RV32M, including the divide special cases.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Result monitors: each completed transfer is checked against its queue head.
    always @(negedge clk) begin
        if (bus1.Evalid === 1'b1 && mready === 1'b1) begin
            if (q1.size() == 0) chk("spurious1", 1, 0);
            else                chk("result1", bus1.MDResult, q1.pop_front());
        end
        if (bus4.Evalid === 1'b1 && mready === 1'b1) begin
            if (q4.size() == 0) chk("spurious4", 1, 0);
            else                chk("result4", bus4.MDResult, q4.pop_front());
        end
    end

    task automatic wait_idle();
        int n;
        @(negedge clk);
        n = 0;
        while (!bus1.Eready && n < 200) begin @(negedge clk); n++; end
        chk("idle_wait", bus1.Eready, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat1, input int lat4);
        int n, l4;
        wait_idle();
        q1.push_back(exp);
        q4.push_back(exp);
        dvalid = 1'b1; mdop = op; srca = a; srcb = b;
        @(posedge clk); #1 dvalid = 1'b0;
        n = 0; l4 = 0;
        do begin
            @(negedge clk); n++;
            if (bus4.Evalid && l4 == 0) l4 = n;
            if (!bus1.Evalid) chk("calc_hs", {bus1.Eready, bus1.Busy}, 2'b01);
        end while (!bus1.Evalid && n < 200);
        chk("latency1", n, lat1);
        chk("latency4", l4, lat4);
        if (mready) begin
            @(negedge clk);
            chk("post_xfer", {bus1.Eready, bus1.Evalid, bus1.Busy}, 3'b100);
        end
    endtask

    task automatic send_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sp;
        sp = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        send(op, a, b, model(op, a, b), sp ? 1 : 33, sp ? 1 : 9);
    endtask

    initial begin
        int n;
        logic [2:0] rop;
        rst = 1'b1; rst_p = 1'b0; dvalid = 1'b0; flush = 1'b0; mready = 1'b1;
        mdop = '0; srca = '0; srcb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset1", {bus1.Eready, bus1.Evalid, bus1.Busy, bus1.MDResult}, {3'b100, 32'h0});
        chk("reset4", {bus4.Eready, bus4.Evalid, bus4.Busy, bus4.MDResult}, {3'b100, 32'h0});

        send(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 9);
        send(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 9);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 9);
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 9);
        send(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, 9);
        send(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 9);
        send(3'd7, 32'd100,        32'd7,          32'd2,          33, 9);
        send(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1, 1);
        send(3'd6, 32'd5,          32'd0,          32'd5,          1, 1);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          1, 1);

        // Backpressure: result held while Mready is low, then exactly one transfer.
        mready = 1'b0;
        send(3'd5, 32'd1000, 32'd10, 32'd100, 33, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {bus1.Evalid, bus4.Evalid}, 2'b11);
            chk("hold_data", {bus1.MDResult, bus4.MDResult}, {32'd100, 32'd100});
        end
        @(posedge clk); #1 mready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_single", {bus1.Evalid, bus4.Evalid, 2'(q1.size()), 2'(q4.size())}, 6'b000000);

        // Flush in cycle 10 of a MUL; the BPC=4 unit already delivered it in cycle 9.
        wait_idle();
        q4.push_back(model(3'd0, 32'h1234, 32'h5678));
        dvalid = 1'b1; mdop = 3'd0; srca = 32'h1234; srcb = 32'h5678;
        @(posedge clk); #1 dvalid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {bus1.Eready, bus1.Evalid, bus1.Busy}, 3'b100);
        repeat (40) @(negedge clk);
        send(3'd3, 32'd3, 32'd5, 32'd0, 33, 9);

        // Dvalid together with Flush must not be accepted.
        @(negedge clk);
        dvalid = 1'b1; flush = 1'b1; mdop = 3'd0; srca = 32'd9; srcb = 32'd9;
        @(posedge clk); #1 dvalid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_acc1", {bus1.Eready, bus1.Evalid, bus1.Busy}, 3'b100);
        chk("flush_acc4", {bus4.Eready, bus4.Evalid, bus4.Busy}, 3'b100);

        send(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 9);

        // Reset pulse in cycle 4 of a MUL on the BPC=4 unit only.
        wait_idle();
        q1.push_back(32'd42);
        dvalid = 1'b1; mdop = 3'd0; srca = 32'd6; srcb = 32'd7;
        @(posedge clk); #1 dvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_p = 1'b1;
        @(posedge clk); #1 rst_p = 1'b0;
        @(negedge clk);
        chk("rst_mid4", {bus4.Eready, bus4.Evalid, bus4.Busy, bus4.MDResult}, {3'b100, 32'h0});
        n = 0;
        while (q1.size() != 0 && n < 100) begin @(negedge clk); n++; end

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            send_m(rop, $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
        end

        repeat (3) @(negedge clk);
        chk("q1_empty", 32'(q1.size()), 0);
        chk("q4_empty", 32'(q4.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
